// File: rtl/mux_81_pkg.sv
// Shared types and constants for the registered 8:1 single-bit mux.
package mux_81_pkg;
  localparam int   N_IN    = 8;
  localparam int   SEL_W   = 3;
  localparam logic RST_VAL = 1'b0;

  typedef logic [N_IN-1:0]  mux_81_data_t;
  typedef logic [SEL_W-1:0] mux_81_sel_t;
endpackage

// File: rtl/mux_81_sel.sv
// Combinational 8:1 lane select; any code outside 0..7 (X/Z) resolves to 0.
module mux_81_sel
  import mux_81_pkg::*;
(
  input  mux_81_data_t i,
  input  mux_81_sel_t  s,
  output logic         y
);

  always_comb begin
    y = 1'b0;
    case (s)
      3'd0:    y = i[0];
      3'd1:    y = i[1];
      3'd2:    y = i[2];
      3'd3:    y = i[3];
      3'd4:    y = i[4];
      3'd5:    y = i[5];
      3'd6:    y = i[6];
      3'd7:    y = i[7];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_81.sv
// Registered 8:1 mux, y <= i[s]. Define MUX_81_PIPE2_EN for a second output
// stage (latency 2); otherwise latency is 1. Reset is synchronous, active-low.
module mux_81
  import mux_81_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  mux_81_data_t i,
  input  mux_81_sel_t  s,
  output logic         y
);

  logic sel_y;
  logic stage1;

  mux_81_sel u_sel (
    .i (i),
    .s (s),
    .y (sel_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) stage1 <= RST_VAL;
    else        stage1 <= sel_y;
  end

`ifdef MUX_81_PIPE2_EN
  // Extra retiming stage; cleared by the same reset so no stale lane leaks out.
  logic stage2;

  always_ff @(posedge clk) begin
    if (!rst_n) stage2 <= RST_VAL;
    else        stage2 <= stage1;
  end

  assign y = stage2;
`else
  assign y = stage1;
`endif

endmodule

// File: tb/tb_mux_81.sv
// Directed bench for mux_81; each vector carries its hand-computed lane value,
// which is delayed by the build's latency before comparison with y.
module tb_mux_81;
  import mux_81_pkg::*;

`ifdef MUX_81_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  mux_81_data_t i;
  mux_81_sel_t  s;
  logic         y;

  int total = 0;
  int bad   = 0;

  logic exp_pipe [0:LAT-1];

  mux_81 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .s     (s),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: y=%b expected=%b", tag, got, want);
    end
  endtask

  // Apply one vector for one cycle; ev is the hand-computed i[s] (ignored in reset).
  task automatic step(input string tag, input logic rn, input logic [7:0] iv,
                      input logic [2:0] sv, input logic ev);
    rst_n = rn;
    i     = iv;
    s     = sv;
    @(posedge clk);
    if (!rn) begin
      for (int j = 0; j < LAT; j++) exp_pipe[j] = 1'b0;
    end else begin
      for (int j = LAT - 1; j > 0; j--) exp_pipe[j] = exp_pipe[j-1];
      exp_pipe[0] = ev;
    end
    #1 chk(tag, y, exp_pipe[LAT-1]);
  endtask

  initial begin
    rst_n = 1'b0;
    i     = '0;
    s     = '0;
    #2;

    // reset holds y low even with a selected lane at 1
    step("rst0", 1'b0, 8'hFF, 3'b101, 1'b1);
    step("rst1", 1'b0, 8'hFF, 3'b101, 1'b1);
    step("rel0", 1'b1, 8'hFF, 3'b101, 1'b1);
    step("rel1", 1'b1, 8'hFF, 3'b101, 1'b1);

    // walking one: selected lane is always the hot bit
    step("w1_0", 1'b1, 8'b0000_0001, 3'd0, 1'b1);
    step("w1_1", 1'b1, 8'b0000_0010, 3'd1, 1'b1);
    step("w1_2", 1'b1, 8'b0000_0100, 3'd2, 1'b1);
    step("w1_3", 1'b1, 8'b0000_1000, 3'd3, 1'b1);
    step("w1_4", 1'b1, 8'b0001_0000, 3'd4, 1'b1);
    step("w1_5", 1'b1, 8'b0010_0000, 3'd5, 1'b1);
    step("w1_6", 1'b1, 8'b0100_0000, 3'd6, 1'b1);
    step("w1_7", 1'b1, 8'b1000_0000, 3'd7, 1'b1);

    // walking zero: selected lane is always the cold bit
    step("w0_0", 1'b1, 8'b1111_1110, 3'd0, 1'b0);
    step("w0_1", 1'b1, 8'b1111_1101, 3'd1, 1'b0);
    step("w0_2", 1'b1, 8'b1111_1011, 3'd2, 1'b0);
    step("w0_3", 1'b1, 8'b1111_0111, 3'd3, 1'b0);
    step("w0_4", 1'b1, 8'b1110_1111, 3'd4, 1'b0);
    step("w0_5", 1'b1, 8'b1101_1111, 3'd5, 1'b0);
    step("w0_6", 1'b1, 8'b1011_1111, 3'd6, 1'b0);
    step("w0_7", 1'b1, 8'b0111_1111, 3'd7, 1'b0);

    // neighbour lane vs hot lane
    step("mis_s3", 1'b1, 8'b0000_0100, 3'b011, 1'b0);
    step("mis_s2", 1'b1, 8'b0000_0100, 3'b010, 1'b1);
    step("mis_hold", 1'b1, 8'b0000_0100, 3'b010, 1'b1);
    step("mis_s4", 1'b1, 8'b0000_0100, 3'b100, 1'b0);
    step("mix_a", 1'b1, 8'b1010_0101, 3'd5, 1'b1);
    step("mix_b", 1'b1, 8'b1010_0101, 3'd6, 1'b0);
    step("mix_c", 1'b1, 8'b1010_0101, 3'd7, 1'b1);

    // mid-run single-cycle reset pulse
    step("mid_pre0", 1'b1, 8'hFF, 3'b110, 1'b1);
    step("mid_pre1", 1'b1, 8'hFF, 3'b110, 1'b1);
    step("mid_rst",  1'b0, 8'hFF, 3'b110, 1'b1);
    step("mid_post0", 1'b1, 8'hFF, 3'b110, 1'b1);
    step("mid_post1", 1'b1, 8'hFF, 3'b110, 1'b1);
    step("mid_post2", 1'b1, 8'hFF, 3'b110, 1'b1);

    // drain: all-zero data keeps y at 0 after the pipe empties
    step("drain0", 1'b1, 8'h00, 3'd7, 1'b0);
    step("drain1", 1'b1, 8'h00, 3'd0, 1'b0);
    step("drain2", 1'b1, 8'h00, 3'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
